iter_alu: RTL and testbench

- Parametrised, multi-cycle successor to the datapath's combinational ALU.
- Sits between the Y/B operand sources and the 64-bit Z (HI/LO) register path.
- Simple ops complete in one clock. Multiply and divide run iteratively over several clocks, using a start/busy/done handshake that the control unit polls.
- Results are registered and held until the next completion.

---
 rtl/iter_alu.sv | 248 ++++++++++++++++++++++++
 tb/tb_iter_alu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// iter_alu: multi-cycle ALU feeding the 64-bit HI/LO (Z) register path.
// Simple ops finish in one clock. MUL/DIV iterate behind a start/busy/done
// handshake, working on operand magnitudes with a sign fix-up at the end.
// Optional build macro FAST_MUL_EN: MUL uses radix-4 Booth, WIDTH/2 iterations.
// Shift/rotate counts assume WIDTH is a power of two (count = b_in mod WIDTH).
module iter_alu #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_MD = 1'b1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_zero,
    output logic             illegal_op
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);
`ifdef FAST_MUL_EN
    localparam int MUL_ITERS = WIDTH / 2;
`else
    localparam int MUL_ITERS = WIDTH;
`endif

    localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB = 5'b00100, OP_SHR = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110, OP_SHL = 5'b00111, OP_ROR = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001, OP_AND = 5'b01010, OP_OR  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01110, OP_DIV = 5'b01111, OP_NEG = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt;
    // MUL: r_acc = partial product, r_mcand = shifted multiplicand.
    // DIV: r_acc = {remainder, dividend/quotient}, r_mcand[W-1:0] = divisor.
    logic [2*WIDTH-1:0] r_acc, r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_neg_q, r_neg_r;
    logic               r_done, r_dz, r_ill;
    logic [WIDTH-1:0]   r_lo, r_hi;
`ifdef FAST_MUL_EN
    logic               r_bprev, r_fix;
`endif

    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [SHW-1:0]     w_sh, w_sh_inv;
    logic [WIDTH-1:0]   w_simple_lo, w_simple_hi;
    logic               w_ill, w_dz, w_go_mul, w_go_div;
    logic [2*WIDTH-1:0] w_mul_acc, w_mcand_nxt, w_mul_fin, w_mul_res;
    logic [WIDTH-1:0]   w_mplier_nxt;
    logic [WIDTH:0]     w_rem_sh, w_diff;
    logic [2*WIDTH-1:0] w_div_acc;
    logic [WIDTH-1:0]   w_quo_res, w_rem_res;
    logic               w_last;

    assign w_a_neg  = (SIGNED_MD != 1'b0) && a_in[WIDTH-1];
    assign w_b_neg  = (SIGNED_MD != 1'b0) && b_in[WIDTH-1];
    assign w_a_mag  = w_a_neg ? ('0 - a_in) : a_in;
    assign w_b_mag  = w_b_neg ? ('0 - b_in) : b_in;
    assign w_sh     = b_in[SHW-1:0];
    // (-sh) mod WIDTH: for sh=0 both rotate halves are a_in, so the OR still yields a_in
    assign w_sh_inv = SHW'(0) - w_sh;
    assign w_last   = (r_cnt == CW'(1));

    // opcode decode and single-cycle results
    always_comb begin
        w_simple_lo = '0;
        w_simple_hi = '0;
        w_ill       = 1'b0;
        w_dz        = 1'b0;
        w_go_mul    = 1'b0;
        w_go_div    = 1'b0;
        case (opcode)
            OP_ADD:  w_simple_lo = a_in + b_in;
            OP_SUB:  w_simple_lo = a_in - b_in;
            OP_SHR:  w_simple_lo = a_in >> w_sh;
            OP_SHRA: w_simple_lo = $signed(a_in) >>> w_sh;
            OP_SHL:  w_simple_lo = a_in << w_sh;
            OP_ROR:  w_simple_lo = (a_in >> w_sh) | (a_in << w_sh_inv);
            OP_ROL:  w_simple_lo = (a_in << w_sh) | (a_in >> w_sh_inv);
            OP_AND:  w_simple_lo = a_in & b_in;
            OP_OR:   w_simple_lo = a_in | b_in;
            OP_NEG:  w_simple_lo = '0 - b_in;
            OP_NOT:  w_simple_lo = ~b_in;
            OP_MUL:  w_go_mul    = 1'b1;
            OP_DIV: begin
                if (b_in == '0) begin
                    w_simple_lo = '1;
                    w_simple_hi = a_in;
                    w_dz        = 1'b1;
                end else begin
                    w_go_div = 1'b1;
                end
            end
            default: w_ill = 1'b1;
        endcase
    end

`ifdef FAST_MUL_EN
    // radix-4 Booth step; the multiplier is treated as signed, so an unsigned
    // magnitude with its MSB set gets mcand<<WIDTH added back on the last step
    always_comb begin
        w_mul_acc = r_acc;
        case ({r_mplier[1:0], r_bprev})
            3'b001, 3'b010: w_mul_acc = r_acc + r_mcand;
            3'b011:         w_mul_acc = r_acc + (r_mcand << 1);
            3'b100:         w_mul_acc = r_acc - (r_mcand << 1);
            3'b101, 3'b110: w_mul_acc = r_acc - r_mcand;
            default:        w_mul_acc = r_acc;
        endcase
        w_mcand_nxt  = r_mcand << 2;
        w_mplier_nxt = r_mplier >> 2;
        w_mul_fin    = w_mul_acc + (r_fix ? w_mcand_nxt : '0);
    end
`else
    // radix-2 shift-add step
    always_comb begin
        w_mul_acc    = r_acc + (r_mplier[0] ? r_mcand : '0);
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = r_mplier >> 1;
        w_mul_fin    = w_mul_acc;
    end
`endif

    // restoring-division step and final sign correction of both results
    always_comb begin
        w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_diff    = w_rem_sh - {1'b0, r_mcand[WIDTH-1:0]};
        w_div_acc = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                  : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};
        w_quo_res = r_neg_q ? ('0 - w_div_acc[WIDTH-1:0]) : w_div_acc[WIDTH-1:0];
        w_rem_res = r_neg_r ? ('0 - w_div_acc[2*WIDTH-1:WIDTH]) : w_div_acc[2*WIDTH-1:WIDTH];
        w_mul_res = r_neg_q ? ('0 - w_mul_fin) : w_mul_fin;
    end

    // state register
    always_ff @(posedge clock or posedge clear) begin
        if (clear) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && w_go_mul)      w_state_nxt = S_MUL;
                else if (start && w_go_div) w_state_nxt = S_DIV;
            end
            S_MUL, S_DIV: if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // datapath, counter and registered results
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
            r_ill    <= 1'b0;
            r_lo     <= '0;
            r_hi     <= '0;
`ifdef FAST_MUL_EN
            r_bprev  <= 1'b0;
            r_fix    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && w_go_mul) begin
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_cnt    <= CW'(MUL_ITERS);
`ifdef FAST_MUL_EN
                        r_bprev  <= 1'b0;
                        r_fix    <= w_b_mag[WIDTH-1];
`endif
                    end else if (start && w_go_div) begin
                        r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mcand <= {{WIDTH{1'b0}}, w_b_mag};
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_cnt   <= CW'(WIDTH);
                    end else if (start) begin
                        r_lo   <= w_simple_lo;
                        r_hi   <= w_simple_hi;
                        r_dz   <= w_dz;
                        r_ill  <= w_ill;
                        r_done <= 1'b1;
                    end
                end
                S_MUL: begin
                    r_acc    <= w_mul_acc;
                    r_mcand  <= w_mcand_nxt;
                    r_mplier <= w_mplier_nxt;
                    r_cnt    <= r_cnt - CW'(1);
`ifdef FAST_MUL_EN
                    r_bprev  <= r_mplier[1];
`endif
                    if (w_last) begin
                        r_lo   <= w_mul_res[WIDTH-1:0];
                        r_hi   <= w_mul_res[2*WIDTH-1:WIDTH];
                        r_dz   <= 1'b0;
                        r_ill  <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                S_DIV: begin
                    r_acc <= w_div_acc;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_lo   <= w_quo_res;
                        r_hi   <= w_rem_res;
                        r_dz   <= 1'b0;
                        r_ill  <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign result_lo  = r_lo;
    assign result_hi  = r_hi;
    assign div_zero   = r_dz;
    assign illegal_op = r_ill;

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu at WIDTH=32, SIGNED_MD=1.
module tb_iter_alu;
    logic        clock = 1'b0;
    logic        clear, start;
    logic [4:0]  opcode;
    logic [31:0] a_in, b_in;
    logic        busy, done, div_zero, illegal_op;
    logic [31:0] result_lo, result_hi;

    int n_checks = 0;
    int n_errors = 0;
    int edges, busy_cnt, done_cnt;

`ifdef FAST_MUL_EN
    localparam int MUL_EDGES = 17;
`else
    localparam int MUL_EDGES = 33;
`endif

    iter_alu #(.WIDTH(32), .SIGNED_MD(1'b1)) dut (
        .clock(clock), .clear(clear), .start(start), .opcode(opcode),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
        .result_lo(result_lo), .result_hi(result_hi),
        .div_zero(div_zero), .illegal_op(illegal_op)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // drive one start cycle; returns 1ns after the sampling edge
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start = 1'b1; opcode = op; a_in = a; b_in = b;
        @(posedge clock);
        #1;
        start = 1'b0; a_in = 32'hDEAD_BEEF; b_in = 32'h0;
    endtask

    // e0 = edges already elapsed, counting the start edge
    task automatic wait_done(input int e0, output int e, output int bc);
        e  = e0;
        bc = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && e < 120) begin
            @(posedge clock);
            #1;
            e++;
            if (busy === 1'b1) bc++;
        end
    endtask

    initial begin
        clear = 1'b1; start = 1'b0; opcode = 5'b0; a_in = '0; b_in = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_lo", result_lo, 0);
        chk("rst_hi", result_hi, 0);
        chk("rst_dz", div_zero, 0);
        chk("rst_ill", illegal_op, 0);
        @(negedge clock);
        clear = 1'b0;

        issue(5'b01111, 32'd9, 32'd0);
        chk("div0_done", done, 1);
        chk("div0_busy", busy, 0);
        chk("div0_lo", result_lo, 32'hFFFF_FFFF);
        chk("div0_hi", result_hi, 32'd9);
        chk("div0_flag", div_zero, 1);
        @(posedge clock); #1;
        chk("div0_done_drop", done, 0);
        chk("div0_hold", result_lo, 32'hFFFF_FFFF);

        issue(5'b01010, 32'h0000_F0F0, 32'h0000_FF00);
        chk("and_done", done, 1);
        chk("and_lo", result_lo, 32'h0000_F000);
        chk("and_hi", result_hi, 0);
        chk("and_dz", div_zero, 0);

        issue(5'b11111, 32'h1234, 32'h5678);
        chk("ill_done", done, 1);
        chk("ill_lo", result_lo, 0);
        chk("ill_hi", result_hi, 0);
        chk("ill_flag", illegal_op, 1);

        issue(5'b00011, 32'hFFFF_FFFF, 32'd1);
        chk("addwrap_done", done, 1);
        chk("addwrap_lo", result_lo, 0);
        chk("addwrap_hi", result_hi, 0);
        chk("addwrap_ill", illegal_op, 0);

        issue(5'b00110, 32'h8000_0000, 32'd4);
        chk("shra", result_lo, 32'hF800_0000);
        issue(5'b01001, 32'h8000_0001, 32'd33);
        chk("rol33", result_lo, 32'h0000_0003);
        issue(5'b01000, 32'h0000_0001, 32'd1);
        chk("ror1", result_lo, 32'h8000_0000);
        issue(5'b00101, 32'hA5A5_0000, 32'd32);
        chk("shr_cnt0", result_lo, 32'hA5A5_0000);
        issue(5'b00111, 32'h0000_0001, 32'd31);
        chk("shl31", result_lo, 32'h8000_0000);
        issue(5'b10000, 32'h0, 32'd1);
        chk("neg1", result_lo, 32'hFFFF_FFFF);
        issue(5'b10001, 32'h0, 32'h0F0F_0000);
        chk("not", result_lo, 32'hF0F0_FFFF);

        // MUL -3*7 with a start pulse injected while busy
        issue(5'b01110, 32'hFFFF_FFFD, 32'd7);
        chk("mul_busy", busy, 1);
        chk("mul_nodone", done, 0);
        @(negedge clock);
        start = 1'b1; opcode = 5'b00011; a_in = 32'd100; b_in = 32'd200;
        @(posedge clock); #1;
        start = 1'b0;
        chk("mul_ignore_busy", busy, 1);
        wait_done(2, edges, busy_cnt);
        chk("mul_edges", edges, MUL_EDGES);
        chk("mul_lo", result_lo, 32'hFFFF_FFEB);
        chk("mul_hi", result_hi, 32'hFFFF_FFFF);
        chk("mul_busy_end", busy, 0);
        @(posedge clock); #1;
        chk("mul_done_drop", done, 0);

        issue(5'b01110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1, edges, busy_cnt);
        chk("mul_m1m1_lo", result_lo, 32'd1);
        chk("mul_m1m1_hi", result_hi, 32'd0);
        issue(5'b01110, 32'h8000_0000, 32'h7FFF_FFFF);
        wait_done(1, edges, busy_cnt);
        chk("mul_big_lo", result_lo, 32'h8000_0000);
        chk("mul_big_hi", result_hi, 32'hC000_0000);

        issue(5'b01111, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, edges, busy_cnt);
        chk("divmin_lo", result_lo, 32'h8000_0000);
        chk("divmin_hi", result_hi, 32'h0);
        chk("divmin_dz", div_zero, 0);

        issue(5'b01111, 32'hFFFF_FFF9, 32'd2);
        wait_done(1, edges, busy_cnt);
        chk("div_edges", edges, 33);
        chk("div_busy_cycles", busy_cnt, 32);
        chk("div_lo", result_lo, 32'hFFFF_FFFD);
        chk("div_hi", result_hi, 32'hFFFF_FFFF);

        // clear during a MUL at cycle 5
        issue(5'b01110, 32'd5, 32'd6);
        repeat (4) begin @(posedge clock); #1; end
        chk("pre_clear_busy", busy, 1);
        #2;
        clear = 1'b1;
        #1;
        chk("clr_busy", busy, 0);
        chk("clr_lo", result_lo, 0);
        chk("clr_hi", result_hi, 0);
        chk("clr_done", done, 0);
        @(negedge clock);
        clear = 1'b0;
        done_cnt = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done === 1'b1) done_cnt++;
        end
        chk("clr_no_done", done_cnt, 0);
        chk("clr_lo_held", result_lo, 0);

        issue(5'b00011, 32'd2, 32'd3);
        chk("add23_done", done, 1);
        chk("add23_lo", result_lo, 32'd5);

        // back-to-back single-cycle ops
        issue(5'b00011, 32'd10, 32'd20);
        chk("b2b_add_done", done, 1);
        chk("b2b_add", result_lo, 32'd30);
        issue(5'b00100, 32'd5, 32'd7);
        chk("b2b_sub_done", done, 1);
        chk("b2b_sub", result_lo, 32'hFFFF_FFFE);
        issue(5'b01011, 32'h0000_00F0, 32'h0000_000F);
        chk("b2b_or_done", done, 1);
        chk("b2b_or", result_lo, 32'h0000_00FF);
        @(posedge clock); #1;
        chk("b2b_done_drop", done, 0);
        chk("b2b_hold", result_lo, 32'h0000_00FF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
